// File: rtl/uart_tx_fifo_if.sv
// Transmit handshake between the core and the UART transmit FIFO.
//   tx_ready  core -> fifo  one-cycle write strobe
//   sdata     core -> fifo  byte to send, valid with tx_ready
//   txd       fifo -> line  UART serial output, idle high
//   busy      fifo -> core  FIFO non-empty or frame in progress
//   fifo_full fifo -> core  FIFO holds its full depth
//   overflow  fifo -> core  sticky dropped-byte flag
interface uart_tx_fifo_if;
  logic       tx_ready;
  logic [7:0] sdata;
  logic       txd;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  modport master (output tx_ready, sdata, input txd, busy, fifo_full, overflow);
  modport slave  (input tx_ready, sdata, output txd, busy, fifo_full, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with an input FIFO. Absorbs one-cycle write strobes
// from the core, queues the bytes and shifts them out LSB-first on txd.
// Bytes arriving while the FIFO is full (and nothing pops on that edge) are
// dropped and flagged through the sticky overflow output.
//   clk   clock
//   rstn  synchronous active-low reset
//   bus   uart_tx_fifo_if.slave (tx_ready, sdata in; txd, busy, fifo_full, overflow out)
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG   = 4
) (
  input  logic            clk,
  input  logic            rstn,
  uart_tx_fifo_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int BW    = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;
  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic [7:0]           mem_q [DEPTH];

  logic pop;
  logic push;
  logic baud_end;

  assign baud_end = (baud_q == BW'(CLK_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          txd_d   = 1'b0;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = '0;
          baud_d  = '0;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            // Next bit is shift_q[1], i.e. bit 0 of the shifted value.
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so bursts carry no idle gap.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    push     = bus.tx_ready & ((count_q != (DEPTH_LOG+1)'(DEPTH)) | pop);
    ovf_d    = ovf_q | (bus.tx_ready & ~push);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    busy_d = (state_d != IDLE) | (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      mem_q[wr_ptr_q] <= bus.sdata;
    end
  end

  assign bus.txd       = txd_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = ovf_q;
  assign bus.fifo_full = (count_q == (DEPTH_LOG+1)'(DEPTH));

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int C     = 4;
  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;
  localparam int FRAME = 10 * C;

  logic clk;
  logic rstn;
  uart_tx_fifo_if intf ();

  uart_tx_fifo #(.CLK_PER_BIT(C), .DEPTH_LOG(DL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: a byte queue plus the position inside the current frame.
  int   m_q[$];
  bit   m_started = 0;
  bit   m_active;
  int   m_ctr;
  int   m_byte;
  bit   m_ovf;

  always @(posedge clk) begin
    bit popped;
    if (!rstn) begin
      m_q.delete();
      m_active  = 0;
      m_ctr     = 0;
      m_ovf     = 0;
      m_started = 1;
    end else if (m_started) begin
      popped = 0;
      if (m_active) begin
        if (m_ctr == FRAME - 1) begin
          if (m_q.size() > 0) begin
            m_byte = m_q.pop_front(); m_ctr = 0; popped = 1;
          end else begin
            m_active = 0;
          end
        end else begin
          m_ctr++;
        end
      end else if (m_q.size() > 0) begin
        m_byte = m_q.pop_front(); m_active = 1; m_ctr = 0; popped = 1;
      end
      if (intf.tx_ready) begin
        if (m_q.size() < DEPTH) m_q.push_back(int'(intf.sdata));
        else m_ovf = 1;
      end
    end
  end

  function automatic logic model_txd();
    logic [9:0] fr;
    if (!m_active) return 1'b1;
    fr = {1'b1, m_byte[7:0], 1'b0};
    return fr[m_ctr / C];
  endfunction

  always @(negedge clk) begin
    if (m_started) begin
      chk("cyc_txd",       intf.txd,       model_txd());
      chk("cyc_busy",      intf.busy,      (m_active || m_q.size() > 0));
      chk("cyc_fifo_full", intf.fifo_full, (m_q.size() == DEPTH));
      chk("cyc_overflow",  intf.overflow,  m_ovf);
    end
  end

  // Line decoder: turns txd back into bytes by sampling mid-bit.
  int       dec_q[$];
  bit       d_act = 0;
  int       d_cnt;
  logic [7:0] d_sh;

  always @(negedge clk) begin
    if (!rstn) begin
      d_act = 0;
    end else if (!d_act) begin
      if (intf.txd === 1'b0) begin d_act = 1; d_cnt = 0; end
    end else begin
      d_cnt++;
      if (d_cnt % C == 2 && d_cnt / C >= 1 && d_cnt / C <= 8)
        d_sh = {intf.txd, d_sh[7:1]};
      if (d_cnt == 9 * C + 2) begin
        chk("stop_bit", intf.txd, 1'b1);
        dec_q.push_back(int'(d_sh));
        d_act = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input logic [7:0] b);
    intf.tx_ready = 1'b1;
    intf.sdata    = b;
    @(posedge clk); #1;
    intf.tx_ready = 1'b0;
    intf.sdata    = 8'($urandom);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (intf.busy === 1'b1 && n < 600) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic chk_dec(input string name, input int exp[$]);
    chk({name, "_count"}, dec_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dec_q.size(); i++)
      chk({name, "_byte"}, dec_q[i], exp[i]);
  endtask

  initial begin
    int n;
    logic [9:0] fr;
    rstn          = 1'b0;
    intf.tx_ready = 1'b0;
    intf.sdata    = 8'h00;
    tick(3);
    rstn = 1'b1;

    // 1: idle after reset
    tick(20);
    chk("rst_txd", intf.txd, 1'b1);
    chk("rst_busy", intf.busy, 1'b0);
    chk("rst_full", intf.fifo_full, 1'b0);
    chk("rst_ovf", intf.overflow, 1'b0);

    // 2: single byte A5, bit-exact waveform
    dec_q.delete();
    strobe(8'hA5);
    chk("a5_busy_at_strobe", intf.busy, 1'b1);
    chk("a5_txd_at_strobe", intf.txd, 1'b1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < C; j++) begin
        tick(1);
        chk("a5_wave", intf.txd, fr[k]);
      end
    wait_idle(n);
    chk("a5_busy_tail", n, 1);
    chk_dec("a5_dec", '{8'hA5});

    // 3: two bytes back to back
    do_reset();
    dec_q.delete();
    strobe(8'h31);
    strobe(8'h32);
    wait_idle(n);
    chk("b2b_busy_len", n, 80);
    chk_dec("b2b_dec", '{8'h31, 8'h32});

    // 4: overflow on the sixth byte
    do_reset();
    dec_q.delete();
    for (int i = 1; i <= 6; i++) strobe(8'(i));
    chk("ovf_set", intf.overflow, 1'b1);
    chk("ovf_full", intf.fifo_full, 1'b1);
    wait_idle(n);
    chk("ovf_busy_len", n, 196);
    chk("ovf_sticky", intf.overflow, 1'b1);
    chk_dec("ovf_dec", '{1, 2, 3, 4, 5});

    // 5: reset during DATA bit 3 of 55 with two bytes queued
    do_reset();
    dec_q.delete();
    strobe(8'h55);
    strobe(8'hAA);
    strobe(8'hCC);
    tick(17);
    rstn = 1'b0;
    tick(1);
    chk("abort_txd", intf.txd, 1'b1);
    chk("abort_busy", intf.busy, 1'b0);
    rstn = 1'b1;
    tick(60);
    chk("abort_busy_after", intf.busy, 1'b0);
    chk("abort_frames", dec_q.size(), 0);

    // 6: push and pop on the same edge while full
    do_reset();
    dec_q.delete();
    for (int i = 0; i < 5; i++) strobe(8'h10 + 8'(i));
    chk("full_before", intf.fifo_full, 1'b1);
    n = 0;
    while (!(m_active && m_ctr == FRAME - 1) && n < 200) begin tick(1); n++; end
    chk("stop_end_found", (n < 200), 1'b1);
    strobe(8'h77);
    chk("same_edge_ovf", intf.overflow, 1'b0);
    chk("same_edge_full", intf.fifo_full, 1'b1);
    wait_idle(n);
    chk("same_edge_ovf_end", intf.overflow, 1'b0);
    chk_dec("same_edge_dec", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h77});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
